equation_round_scheduler: RTL and testbench

- Top-level sequencer for the alarm-dismiss round.
- Launches the three equation solver units one at a time with a one-hot start handshake.
- Runs a per-equation countdown in seconds and presents it on OngoingTimer to the active solver.
- Counts wrong submissions, then routes the round to the penalty sequencer or directly to done.

---
 rtl/alarm_pkg.sv | 23 ++
 rtl/equation_round_scheduler_if.sv | 27 ++
 rtl/second_tick_gen.sv | 29 ++
 rtl/equation_round_scheduler.sv | 107 ++++++++++
 tb/tb_equation_round_scheduler.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/alarm_pkg.sv
// Shared widths and state encoding for the alarm-dismiss round scheduler.
package alarm_pkg;
  localparam int NUM_EQ  = 3;
  localparam int IDX_W   = 2;
  localparam int TIMER_W = 7;
  localparam int ATT_W   = 4;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LAUNCH   = 3'd1;
  localparam logic [2:0] ST_SOLVE    = 3'd2;
  localparam logic [2:0] ST_ADVANCE  = 3'd3;
  localparam logic [2:0] ST_SEQUENCE = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_LAUNCH   = ST_LAUNCH,
    S_SOLVE    = ST_SOLVE,
    S_ADVANCE  = ST_ADVANCE,
    S_SEQUENCE = ST_SEQUENCE,
    S_DONE     = ST_DONE
  } state_t;
endpackage

// File: rtl/equation_round_scheduler_if.sv
// Round-level handshake between the scheduler, the solvers and the penalty sequencer.
interface equation_round_scheduler_if;
  import alarm_pkg::*;
  logic               Start;
  logic [NUM_EQ-1:0]  eq_valid;
  logic [NUM_EQ-1:0]  eq_correct;
  logic               sequence_done;
  logic [NUM_EQ-1:0]  eq_start;
  logic [IDX_W-1:0]   eq_index;
  logic [TIMER_W-1:0] OngoingTimer;
  logic               Wrong;
  logic               timeout_seen;
  logic [ATT_W-1:0]   attempt_count;
  logic               sequence_req;
  logic               Done;

  modport master (
    output Start, eq_valid, eq_correct, sequence_done,
    input  eq_start, eq_index, OngoingTimer, Wrong, timeout_seen,
           attempt_count, sequence_req, Done
  );
  modport slave (
    input  Start, eq_valid, eq_correct, sequence_done,
    output eq_start, eq_index, OngoingTimer, Wrong, timeout_seen,
           attempt_count, sequence_req, Done
  );
endinterface

// File: rtl/second_tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled, pulses tick on wrap.
module second_tick_gen #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(TICK_DIV - 1));
  assign tick = en & ~clr & wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = wrap ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/equation_round_scheduler.sv
// Sequences three equation solvers with a per-equation countdown, tracks wrong
// submissions/timeouts and routes the round to the penalty sequencer or done.
module equation_round_scheduler
  import alarm_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50000000,
  parameter int unsigned TIMEOUT_S    = 20,
  parameter int unsigned MAX_ATTEMPTS = 15
) (
  input  logic                        Clock,
  input  logic                        Reset,
  equation_round_scheduler_if.slave   bus
);
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               wrong_q, wrong_d;
  logic               tmo_q, tmo_d;
  logic [ATT_W-1:0]   att_q, att_d;
  logic               tick, hit, ok;

  second_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (Clock),
    .rst  (Reset),
    .clr  (state_q == S_LAUNCH),
    .en   (state_q == S_SOLVE),
    .tick (tick)
  );

  // Only the active solver's result lines matter.
  assign hit = bus.eq_valid[idx_q];
  assign ok  = bus.eq_correct[idx_q];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    wrong_d = wrong_q;
    tmo_d   = tmo_q;
    att_d   = att_q;
    case (state_q)
      S_IDLE: if (bus.Start) begin
        state_d = S_LAUNCH;
        idx_d   = '0;
        wrong_d = 1'b0;
        tmo_d   = 1'b0;
        att_d   = '0;
      end
      S_LAUNCH: begin
        timer_d = TIMER_W'(TIMEOUT_S);
        state_d = S_SOLVE;
      end
      S_SOLVE: begin
        if (tick) timer_d = (timer_q == '0) ? '0 : timer_q - 1'b1;
        if (hit && !ok) begin
          wrong_d = 1'b1;
          att_d   = (att_q >= ATT_W'(MAX_ATTEMPTS)) ? att_q : att_q + 1'b1;
        end
        // A correct answer on the expiring tick still counts as solved.
        if (hit && ok) state_d = S_ADVANCE;
        else if (tick && timer_q == TIMER_W'(1)) begin
          wrong_d = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        if (idx_q == IDX_W'(NUM_EQ - 1)) state_d = wrong_q ? S_SEQUENCE : S_DONE;
        else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_SEQUENCE: if (bus.sequence_done) state_d = S_DONE;
      S_DONE:     if (!bus.Start) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      wrong_q <= 1'b0;
      tmo_q   <= 1'b0;
      att_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      wrong_q <= wrong_d;
      tmo_q   <= tmo_d;
      att_q   <= att_d;
    end
  end

  assign bus.eq_start      = (state_q == S_LAUNCH || state_q == S_SOLVE)
                             ? NUM_EQ'(1) << idx_q : '0;
  assign bus.eq_index      = idx_q;
  assign bus.OngoingTimer  = timer_q;
  assign bus.Wrong         = wrong_q;
  assign bus.timeout_seen  = tmo_q;
  assign bus.attempt_count = att_q;
  assign bus.sequence_req  = (state_q == S_SEQUENCE);
  assign bus.Done          = (state_q == S_DONE);
endmodule

// File: tb/tb_equation_round_scheduler.sv
// Directed bench: short-timeout instance for round flow, long-timeout instance
// for attempt saturation.
module tb_equation_round_scheduler;
  logic Clock = 1'b0;
  logic Reset;
  int   n_chk = 0;
  int   n_bad = 0;
  logic sreq_seen;

  always #5 Clock = ~Clock;

  equation_round_scheduler_if ia();
  equation_round_scheduler_if ib();

  equation_round_scheduler #(.TICK_DIV(4), .TIMEOUT_S(3), .MAX_ATTEMPTS(15)) dut_a (
    .Clock (Clock), .Reset (Reset), .bus (ia.slave)
  );
  equation_round_scheduler #(.TICK_DIV(4), .TIMEOUT_S(127), .MAX_ATTEMPTS(15)) dut_b (
    .Clock (Clock), .Reset (Reset), .bus (ib.slave)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    sreq_seen = sreq_seen | ia.sequence_req;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic pulse(input int i, input bit correct);
    ia.eq_valid   = 3'(1 << i);
    ia.eq_correct = correct ? 3'(1 << i) : 3'b000;
    step();
    ia.eq_valid   = '0;
    ia.eq_correct = '0;
  endtask

  task automatic wait_start(input int i);
    for (int k = 0; k < 20 && ia.eq_start != 3'(1 << i); k++) step();
    chk("wait_start", ia.eq_start, 1 << i);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_eq_start"}, ia.eq_start, 0);
    chk({pfx, "_eq_index"}, ia.eq_index, 0);
    chk({pfx, "_timer"},    ia.OngoingTimer, 0);
    chk({pfx, "_wrong"},    ia.Wrong, 0);
    chk({pfx, "_tmo"},      ia.timeout_seen, 0);
    chk({pfx, "_att"},      ia.attempt_count, 0);
    chk({pfx, "_sreq"},     ia.sequence_req, 0);
    chk({pfx, "_done"},     ia.Done, 0);
  endtask

  initial begin
    sreq_seen = 1'b0;
    Reset = 1'b1;
    ia.Start = 0; ia.eq_valid = '0; ia.eq_correct = '0; ia.sequence_done = 0;
    ib.Start = 0; ib.eq_valid = '0; ib.eq_correct = '0; ib.sequence_done = 0;
    steps(2);
    Reset = 1'b0;
    chk_all_zero("rst");

    // happy path
    ia.Start = 1;
    step();
    chk("hp_start_lat", ia.eq_start, 1);
    for (int i = 0; i < 3; i++) begin
      wait_start(i);
      chk("hp_index", ia.eq_index, i);
      steps(5);
      if (i == 0) chk("hp_timer_first_dec", ia.OngoingTimer, 2);
      pulse(i, 1'b1);
      chk("hp_advance_gap", ia.eq_start, 0);
    end
    step();
    chk("hp_done", ia.Done, 1);
    chk("hp_wrong", ia.Wrong, 0);
    chk("hp_att", ia.attempt_count, 0);
    chk("hp_sreq_seen", sreq_seen, 0);
    steps(3);
    chk("hp_done_held", ia.Done, 1);
    chk("hp_no_relaunch", ia.eq_start, 0);
    ia.Start = 0;
    step();
    chk("hp_idle", ia.Done, 0);

    // wrong then correct, plus inactive-index results
    ia.Start = 1;
    steps(2);
    ia.eq_valid = 3'b110; ia.eq_correct = 3'b110;
    step();
    ia.eq_valid = '0; ia.eq_correct = '0;
    chk("inactive_ignored", ia.eq_start, 1);
    pulse(0, 1'b0);
    chk("wc_att", ia.attempt_count, 1);
    chk("wc_wrong", ia.Wrong, 1);
    chk("wc_stay", ia.eq_start, 1);
    pulse(0, 1'b1);
    steps(2); pulse(1, 1'b1);
    steps(2); pulse(2, 1'b1);
    step();
    chk("wc_sreq", ia.sequence_req, 1);
    steps(3);
    chk("wc_sreq_hold", ia.sequence_req, 1);
    ia.sequence_done = 1;
    step();
    ia.sequence_done = 0;
    chk("wc_done", ia.Done, 1);
    chk("wc_sreq_drop", ia.sequence_req, 0);
    chk("wc_att_held", ia.attempt_count, 1);
    chk("wc_tmo", ia.timeout_seen, 0);
    ia.Start = 0;
    step();

    // timeout on eq0
    ia.Start = 1;
    step();
    step();  chk("to_t3", ia.OngoingTimer, 3);
    steps(4); chk("to_t2", ia.OngoingTimer, 2);
    steps(4); chk("to_t1", ia.OngoingTimer, 1);
    chk("to_wrong_pre", ia.Wrong, 0);
    steps(4); chk("to_t0", ia.OngoingTimer, 0);
    chk("to_wrong", ia.Wrong, 1);
    chk("to_tmo", ia.timeout_seen, 1);
    chk("to_adv", ia.eq_start, 0);
    step();   chk("to_idx1", ia.eq_index, 1);
    chk("to_start1", ia.eq_start, 2);
    step();   chk("to_reload", ia.OngoingTimer, 3);
    pulse(1, 1'b1);
    steps(2); pulse(2, 1'b1);
    step();   chk("to_sreq", ia.sequence_req, 1);
    ia.sequence_done = 1; step(); ia.sequence_done = 0;
    chk("to_att", ia.attempt_count, 0);
    ia.Start = 0;
    step();

    // correct on the expiring tick, then wrong on the expiring tick
    ia.Start = 1;
    step();
    steps(12);
    chk("sim_t1", ia.OngoingTimer, 1);
    pulse(0, 1'b1);
    chk("sim_wrong", ia.Wrong, 0);
    chk("sim_tmo", ia.timeout_seen, 0);
    chk("sim_adv", ia.eq_start, 0);
    step();
    chk("sim_idx1", ia.eq_index, 1);
    steps(12);
    chk("wt_t1", ia.OngoingTimer, 1);
    pulse(1, 1'b0);
    chk("wt_att", ia.attempt_count, 1);
    chk("wt_wrong", ia.Wrong, 1);
    chk("wt_tmo", ia.timeout_seen, 1);
    chk("wt_adv", ia.eq_start, 0);

    // reset mid-SOLVE on eq1 with two wrong attempts
    Reset = 1; ia.Start = 0; step(); Reset = 0;
    ia.Start = 1;
    steps(2);
    pulse(0, 1'b0);
    pulse(0, 1'b1);
    steps(2);
    pulse(1, 1'b0);
    chk("mr_att2", ia.attempt_count, 2);
    chk("mr_idx1", ia.eq_index, 1);
    Reset = 1;
    step();
    Reset = 0;
    chk_all_zero("mr");
    step();
    chk("mr_relaunch", ia.eq_start, 1);
    chk("mr_relaunch_idx", ia.eq_index, 0);

    // attempt_count saturation on the long-timeout instance
    ib.Start = 1;
    step(); step();
    ib.eq_valid = 3'b001; ib.eq_correct = 3'b000;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 14) chk("sat_14", ib.attempt_count, 14);
      if (k == 15) chk("sat_15", ib.attempt_count, 15);
    end
    ib.eq_valid = '0;
    chk("sat_hold", ib.attempt_count, 15);
    chk("sat_wrong", ib.Wrong, 1);
    chk("sat_stay", ib.eq_start, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
